// File: rtl/vend_actuator_seq_if.sv
// Controller-side bundle of the vending actuator sequencer:
// command strobes in, status flags out.
interface vend_actuator_seq_if;
  logic cmd_1;
  logic cmd_2;
  logic cmd_3;
  logic busy;
  logic done;
  logic fault;
  logic overrun;

  modport master (
    output cmd_1, cmd_2, cmd_3,
    input  busy, done, fault, overrun
  );

  modport slave (
    input  cmd_1, cmd_2, cmd_3,
    output busy, done, fault, overrun
  );
endinterface

// File: rtl/vend_actuator_seq.sv
// Actuator sequencer: queues dispense/change strobes, pulses motors, awaits sense.
// Define VEND_COUNT_EN to add the 8-bit confirmed-dispense counter output.
module vend_actuator_seq #(
  parameter int PULSE_CYCLES   = 50000,
  parameter int TIMEOUT_CYCLES = 200000,
  parameter int CNT_W          = 18
) (
  input  logic               clock,
  input  logic               reset,
  vend_actuator_seq_if.slave ctl,
  input  logic               drop_sense,
  input  logic               coin_sense,
  input  logic               fault_clr,
  output logic               act_a,
  output logic               act_b,
  output logic               act_chg
`ifdef VEND_COUNT_EN
  ,
  output logic [7:0]         vend_count
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN_A,
    S_RUN_B,
    S_RUN_C,
    S_WAIT,
    S_DONE,
    S_FAULT
  } state_t;

  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LD   = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [2:0]       pend_q, pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             latch_q, latch_d;
  logic [1:0]       job_q, job_d;
  logic             ovr_q, ovr_d;
  logic             busy_q, done_q, fault_q;
  logic             drop_s1, drop_s2;
  logic             coin_s1, coin_s2;
  logic [2:0]       cmd;
  logic [2:0]       pend_cap;
  logic [2:0]       pend_left;
  logic [2:0]       start_vec;
  logic             start;
  logic             sense;
  logic             seen;
  logic             vend_inc;

  function automatic logic [1:0] first_job(input logic [2:0] p);
    if (p[0])      return 2'd0;
    else if (p[1]) return 2'd1;
    else           return 2'd2;
  endfunction

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    cnt_d     = cnt_q;
    latch_d   = latch_q;
    job_d     = job_q;
    ovr_d     = ovr_q;
    start     = 1'b0;
    start_vec = 3'b000;
    vend_inc  = 1'b0;
    cmd       = {ctl.cmd_3, ctl.cmd_2, ctl.cmd_1};
    pend_cap  = pend_q | cmd;
    pend_left = pend_cap & ~(3'b001 << job_q);
    sense     = (job_q == 2'd2) ? coin_s2 : drop_s2;
    seen      = latch_q | sense;

    if (state_q != S_FAULT) begin
      pend_d = pend_cap;
      if ((cmd & pend_q) != 3'b000) ovr_d = 1'b1;
    end
    if (fault_clr) ovr_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (pend_cap != 3'b000) begin
          start     = 1'b1;
          start_vec = pend_cap;
        end
      end
      S_RUN_A, S_RUN_B, S_RUN_C: begin
        latch_d = seen;
        if (cnt_q == '0) begin
          state_d = S_WAIT;
          cnt_d   = TMO_LD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_WAIT: begin
        if (seen) begin
          pend_d   = pend_left;
          vend_inc = (job_q != 2'd2);
          if (pend_left != 3'b000) begin
            start     = 1'b1;
            start_vec = pend_left;
          end else begin
            state_d = S_DONE;
          end
        end else if (cnt_q == '0) begin
          state_d = S_FAULT;
          pend_d  = 3'b000;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_FAULT: if (fault_clr) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Entering any RUN state restarts the pulse timer and the sense latch.
    if (start) begin
      job_d   = first_job(start_vec);
      cnt_d   = PULSE_LD;
      latch_d = 1'b0;
      unique case (first_job(start_vec))
        2'd0:    state_d = S_RUN_A;
        2'd1:    state_d = S_RUN_B;
        default: state_d = S_RUN_C;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pend_q  <= 3'b000;
      cnt_q   <= '0;
      latch_q <= 1'b0;
      job_q   <= 2'd0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      act_a   <= 1'b0;
      act_b   <= 1'b0;
      act_chg <= 1'b0;
      drop_s1 <= 1'b0;
      drop_s2 <= 1'b0;
      coin_s1 <= 1'b0;
      coin_s2 <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      latch_q <= latch_d;
      job_q   <= job_d;
      ovr_q   <= ovr_d;
      busy_q  <= (state_d != S_IDLE && state_d != S_DONE)
                 || (pend_d != 3'b000);
      done_q  <= (state_d == S_DONE);
      fault_q <= (state_d == S_FAULT);
      act_a   <= (state_d == S_RUN_A);
      act_b   <= (state_d == S_RUN_B);
      act_chg <= (state_d == S_RUN_C);
      drop_s1 <= drop_sense;
      drop_s2 <= drop_s1;
      coin_s1 <= coin_sense;
      coin_s2 <= coin_s1;
    end
  end

`ifdef VEND_COUNT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset)         vend_count <= 8'd0;
    else if (vend_inc) vend_count <= vend_count + 8'd1;
  end
`else
  logic unused_inc;
  assign unused_inc = vend_inc;
`endif

  assign ctl.busy    = busy_q;
  assign ctl.done    = done_q;
  assign ctl.fault   = fault_q;
  assign ctl.overrun = ovr_q;

endmodule

// File: tb/tb_vend_actuator_seq.sv
// Bench for vend_actuator_seq: job-level reference model plus directed cases.
module tb_vend_actuator_seq;
  localparam int P = 4;
  localparam int T = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic drop_sense = 1'b0;
  logic coin_sense = 1'b0;
  logic fault_clr = 1'b0;
  logic act_a, act_b, act_chg;
`ifdef VEND_COUNT_EN
  logic [7:0] vend_count;
`endif

  int total = 0;
  int bad = 0;

  vend_actuator_seq_if bus ();

  vend_actuator_seq #(
    .PULSE_CYCLES(P),
    .TIMEOUT_CYCLES(T),
    .CNT_W(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .ctl(bus),
    .drop_sense(drop_sense),
    .coin_sense(coin_sense),
    .fault_clr(fault_clr),
    .act_a(act_a),
    .act_b(act_b),
    .act_chg(act_chg)
`ifdef VEND_COUNT_EN
    ,
    .vend_count(vend_count)
`endif
  );

  always #5 clock = ~clock;

  // Model: job = -1 when no actuator job is in flight; run counts
  // remaining on-cycles, wt remaining confirmation cycles.
  typedef struct packed {
    int job;
    int run;
    int wt;
    int cnt;
    logic seen;
    logic [2:0] pend;
    logic flt;
    logic ov;
    logic dn;
    logic d1;
    logic d2;
    logic c1;
    logic c2;
  } mst_t;

  mst_t m;

  function automatic mst_t mreset();
    mst_t n;
    n = '0;
    n.job = -1;
    return n;
  endfunction

  function automatic mst_t mstart(input mst_t s);
    mst_t n;
    n = s;
    n.job = s.pend[0] ? 0 : (s.pend[1] ? 1 : 2);
    n.run = P;
    n.seen = 1'b0;
    return n;
  endfunction

  function automatic mst_t mstep(input mst_t s, input logic [2:0] c,
                                 input logic drop, input logic coin,
                                 input logic clr);
    mst_t n;
    logic sen;
    n = s;
    sen = (s.job == 2) ? s.c2 : s.d2;
    n.dn = 1'b0;
    if (s.flt) begin
      if (clr) begin
        n.flt = 1'b0;
        n.ov = 1'b0;
      end
    end else begin
      if ((c & s.pend) != 3'b000) n.ov = 1'b1;
      if (clr) n.ov = 1'b0;
      n.pend = s.pend | c;
      if (s.job >= 0) begin
        n.seen = s.seen | sen;
        if (s.run > 0) begin
          n.run = s.run - 1;
          if (n.run == 0) n.wt = T;
        end else if (n.seen) begin
          n.pend = n.pend & ~(3'b001 << s.job);
          if (s.job < 2) n.cnt = (s.cnt + 1) % 256;
          n.job = -1;
          if (n.pend == 3'b000) n.dn = 1'b1;
          else n = mstart(n);
        end else begin
          n.wt = s.wt - 1;
          if (n.wt == 0) begin
            n.flt = 1'b1;
            n.pend = 3'b000;
            n.job = -1;
          end
        end
      end else if (!s.dn && n.pend != 3'b000) begin
        n = mstart(n);
      end
    end
    n.d2 = s.d1;
    n.d1 = drop;
    n.c2 = s.c1;
    n.c1 = coin;
    return n;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) m <= mreset();
    else m <= mstep(m, {bus.cmd_3, bus.cmd_2, bus.cmd_1},
                    drop_sense, coin_sense, fault_clr);
  end

  logic e_a, e_b, e_c, e_busy;
  assign e_a = (m.job == 0) && (m.run > 0);
  assign e_b = (m.job == 1) && (m.run > 0);
  assign e_c = (m.job == 2) && (m.run > 0);
  assign e_busy = (m.job >= 0) || m.flt || (m.pend != 3'b000);

  task automatic chk1(input string nm, input logic got, input logic want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s at %0t: got=%b want=%b", nm, $time, got, want);
    end
  endtask

  task automatic chk8(input string nm, input logic [7:0] got,
                      input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s at %0t: got=%0d want=%0d", nm, $time, got, want);
    end
  endtask

  always @(negedge clock) begin
    chk1("m_act_a", act_a, e_a);
    chk1("m_act_b", act_b, e_b);
    chk1("m_act_chg", act_chg, e_c);
    chk1("m_busy", bus.busy, e_busy);
    chk1("m_done", bus.done, m.dn);
    chk1("m_fault", bus.fault, m.flt);
    chk1("m_overrun", bus.overrun, m.ov);
`ifdef VEND_COUNT_EN
    chk8("m_vend_count", vend_count, 8'(m.cnt));
`endif
  end

  task automatic step(input logic [2:0] c, input logic d,
                      input logic co, input logic clr);
    @(negedge clock);
    bus.cmd_1 = c[0];
    bus.cmd_2 = c[1];
    bus.cmd_3 = c[2];
    drop_sense = d;
    coin_sense = co;
    fault_clr = clr;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(3'b000, 1'b0, 1'b0, 1'b0);
  endtask

`ifdef VEND_COUNT_EN
  task automatic one_job(input logic [2:0] c, input string nm);
    logic got;
    got = 1'b0;
    step(c, 1'b0, 1'b0, 1'b0);
    step(3'b000, ~c[2], c[2], 1'b0);
    step(3'b000, ~c[2], c[2], 1'b0);
    for (int k = 0; k < 30 && !got; k++) begin
      step(3'b000, 1'b0, 1'b0, 1'b0);
      if (bus.done) got = 1'b1;
    end
    chk1(nm, got, 1'b1);
  endtask
`endif

  initial begin
    bus.cmd_1 = 1'b0;
    bus.cmd_2 = 1'b0;
    bus.cmd_3 = 1'b0;
    idle(2);
    chk1("rst_act_a", act_a, 1'b0);
    chk1("rst_busy", bus.busy, 1'b0);
    chk1("rst_done", bus.done, 1'b0);
    chk1("rst_fault", bus.fault, 1'b0);
    chk1("rst_overrun", bus.overrun, 1'b0);
    step(3'b000, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    idle(2);

    // single A job
    step(3'b001, 1'b0, 1'b0, 1'b0);
    chk1("t1_a_c0", act_a, 1'b0);
    step(3'b000, 1'b0, 1'b0, 1'b0);
    chk1("t1_a_c1", act_a, 1'b1);
    step(3'b000, 1'b0, 1'b0, 1'b0);
    step(3'b000, 1'b1, 1'b0, 1'b0);
    step(3'b000, 1'b1, 1'b0, 1'b0);
    chk1("t1_a_c4", act_a, 1'b1);
    step(3'b000, 1'b1, 1'b0, 1'b0);
    chk1("t1_a_c5", act_a, 1'b0);
    chk1("t1_busy_c5", bus.busy, 1'b1);
    step(3'b000, 1'b0, 1'b0, 1'b0);
    chk1("t1_done_c6", bus.done, 1'b1);
    chk1("t1_busy_c6", bus.busy, 1'b0);
    step(3'b000, 1'b0, 1'b0, 1'b0);
    chk1("t1_done_c7", bus.done, 1'b0);
    idle(3);

    // A plus change
    step(3'b101, 1'b0, 1'b0, 1'b0);
    step(3'b000, 1'b1, 1'b0, 1'b0);
    step(3'b000, 1'b1, 1'b0, 1'b0);
    step(3'b000, 1'b1, 1'b0, 1'b0);
    step(3'b000, 1'b0, 1'b0, 1'b0);
    chk1("t2_a_c4", act_a, 1'b1);
    chk1("t2_chg_c4", act_chg, 1'b0);
    step(3'b000, 1'b0, 1'b0, 1'b0);
    chk1("t2_a_c5", act_a, 1'b0);
    chk1("t2_done_c5", bus.done, 1'b0);
    step(3'b000, 1'b0, 1'b1, 1'b0);
    chk1("t2_chg_c6", act_chg, 1'b1);
    step(3'b000, 1'b0, 1'b1, 1'b0);
    step(3'b000, 1'b0, 1'b1, 1'b0);
    step(3'b000, 1'b0, 1'b0, 1'b0);
    chk1("t2_chg_c9", act_chg, 1'b1);
    step(3'b000, 1'b0, 1'b0, 1'b0);
    chk1("t2_chg_c10", act_chg, 1'b0);
    chk1("t2_done_c10", bus.done, 1'b0);
    step(3'b000, 1'b0, 1'b0, 1'b0);
    chk1("t2_done_c11", bus.done, 1'b1);
    idle(3);

    // timeout into fault, strobe ignored, then clear
    step(3'b010, 1'b0, 1'b0, 1'b0);
    step(3'b000, 1'b0, 1'b0, 1'b0);
    chk1("t3_b_c1", act_b, 1'b1);
    idle(3);
    chk1("t3_b_c4", act_b, 1'b1);
    idle(1);
    chk1("t3_b_c5", act_b, 1'b0);
    idle(7);
    chk1("t3_fault_c12", bus.fault, 1'b0);
    idle(1);
    chk1("t3_fault_c13", bus.fault, 1'b1);
    chk1("t3_busy_c13", bus.busy, 1'b1);
    step(3'b001, 1'b0, 1'b0, 1'b0);
    idle(2);
    chk1("t3_a_c16", act_a, 1'b0);
    chk1("t3_fault_c16", bus.fault, 1'b1);
    step(3'b000, 1'b0, 1'b0, 1'b1);
    step(3'b000, 1'b0, 1'b0, 1'b0);
    chk1("t3_fault_c18", bus.fault, 1'b0);
    chk1("t3_busy_c18", bus.busy, 1'b0);
    chk1("t3_a_c18", act_a, 1'b0);
    idle(3);

    // overrun and queued second job
    step(3'b010, 1'b0, 1'b0, 1'b0);
    step(3'b000, 1'b0, 1'b0, 1'b0);
    step(3'b010, 1'b1, 1'b0, 1'b0);
    chk1("t4_ovr_c2", bus.overrun, 1'b0);
    step(3'b001, 1'b1, 1'b0, 1'b0);
    chk1("t4_ovr_c3", bus.overrun, 1'b1);
    step(3'b000, 1'b0, 1'b0, 1'b0);
    chk1("t4_b_c4", act_b, 1'b1);
    step(3'b000, 1'b0, 1'b0, 1'b0);
    chk1("t4_b_c5", act_b, 1'b0);
    chk1("t4_a_c5", act_a, 1'b0);
    step(3'b000, 1'b0, 1'b0, 1'b0);
    chk1("t4_a_c6", act_a, 1'b1);
    step(3'b000, 1'b1, 1'b0, 1'b0);
    step(3'b000, 1'b1, 1'b0, 1'b0);
    step(3'b000, 1'b0, 1'b0, 1'b0);
    chk1("t4_a_c9", act_a, 1'b1);
    step(3'b000, 1'b0, 1'b0, 1'b0);
    chk1("t4_done_c10", bus.done, 1'b0);
    step(3'b000, 1'b0, 1'b0, 1'b0);
    chk1("t4_done_c11", bus.done, 1'b1);
    chk1("t4_ovr_c11", bus.overrun, 1'b1);
    step(3'b000, 1'b0, 1'b0, 1'b1);
    step(3'b000, 1'b0, 1'b0, 1'b0);
    chk1("t4_ovr_clr", bus.overrun, 1'b0);
    idle(3);

    // reset in the middle of an A pulse
    step(3'b001, 1'b0, 1'b0, 1'b0);
    step(3'b000, 1'b0, 1'b0, 1'b0);
    chk1("t5_a_c1", act_a, 1'b1);
    step(3'b000, 1'b0, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk1("t5_a_async", act_a, 1'b0);
    chk1("t5_busy_async", bus.busy, 1'b0);
    step(3'b000, 1'b0, 1'b0, 1'b0);
    step(3'b000, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    idle(10);
    chk1("t5_a_after", act_a, 1'b0);
    chk1("t5_busy_after", bus.busy, 1'b0);

`ifdef VEND_COUNT_EN
    chk8("t6_cnt_start", vend_count, 8'd0);
    for (int j = 0; j < 257; j++)
      one_job((j % 2 == 0) ? 3'b001 : 3'b010, "t6_prod_done");
    chk8("t6_cnt_wrap", vend_count, 8'd1);
    one_job(3'b100, "t6_chg_done");
    chk8("t6_cnt_chg", vend_count, 8'd1);
    idle(2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vend_actuator_seq.md
Name: vend_actuator_seq

Overview:
Responder for the vending FSM's one-cycle motor command strobes. It captures each command, runs the physical actuators for a fixed pulse time, and waits for mechanical confirmation from sense inputs. It reports busy, done and fault status back to the controller. Sits between the vending FSM outputs and the motor driver pins.

Parameters:
PULSE_CYCLES, 50000, actuator on-time in clock cycles (>=1)
TIMEOUT_CYCLES, 200000, max cycles to wait for confirmation after pulse ends (>=1)
CNT_W, 18, counter width; must hold max(PULSE_CYCLES, TIMEOUT_CYCLES)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; clock clock
cmd_1  input  1  strobe: dispense product A (25 unit item)
cmd_2  input  1  strobe: dispense product B (50 unit item)
cmd_3  input  1  strobe: return one 5 unit coin
drop_sense  input  1  product-drop sensor, async, active-high
coin_sense  input  1  coin-out sensor, async, active-high
fault_clr  input  1  clears FAULT state, synchronous
act_a  output  1  actuator A drive
act_b  output  1  actuator B drive
act_chg  output  1  change actuator drive
busy  output  1  high whenever state != IDLE or any pending bit set
done  output  1  one-cycle pulse when all pending jobs complete
fault  output  1  high while in FAULT
overrun  output  1  sticky; strobe arrived for a job already pending; cleared by reset or fault_clr

Behaviour:
- All outputs are registered. Reset values: act_a=act_b=act_chg=0, busy=0, done=0, fault=0, overrun=0. Pending bits, counters and sense latch are 0. State is IDLE.
- Reset mid-operation forces all actuators off immediately (async) and discards pending jobs.
- drop_sense and coin_sense pass through a 2-flop synchroniser, adding 2 cycles of latency.
- Command capture: any cmd_k high in a cycle sets pending[k] at the next edge, in any state except FAULT. Strobes in FAULT are ignored.
  - If pending[k] is already 1 when cmd_k arrives, set overrun; the job is not queued twice.
  - Simultaneous cmd_1 and cmd_3 (the FSM's A+change combination) set both bits in the same cycle.
- Service order: A, then B, then change. Only one actuator is high at any time.
- States:
  - IDLE: if any pending bit is set, go to the RUN state of the highest-priority job.
  - RUN_A / RUN_B / RUN_CHG:
    - On entry, the actuator goes high, the counter loads, and the sense latch clears.
    - The actuator is high for exactly PULSE_CYCLES cycles, then goes to WAIT.
    - First actuator-high cycle = cycle after the strobe when IDLE with nothing pending (1-cycle latency).
  - WAIT: actuator low, counter loaded with TIMEOUT_CYCLES.
    - Sense latch set (sync sense seen any cycle since RUN entry): clear that pending bit; go to the next RUN if more are pending, else DONE.
    - Counter expires with latch clear: go to FAULT.
    - Relevant sense is drop_sense for A/B and coin_sense for change.
  - DONE: done=1 for one cycle, then IDLE. No DONE pulse between jobs of a batch.
  - FAULT: all actuators 0, fault=1, busy=1, pending bits cleared.
    - fault_clr=1 clears fault and overrun and returns to IDLE the next cycle.
- Sense pulses arriving in IDLE are ignored.
- busy falls in the same cycle done rises.

Optional Feature:
VEND_COUNT_EN
- Defined: adds output port vend_count [7:0], reset 0. It increments by 1 for each confirmed A or B dispense (not change) and wraps 255->0. fault_clr does not clear it.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
All runs use PULSE_CYCLES=4, TIMEOUT_CYCLES=8.
1. Single job: cmd_1 at cycle 0, drop_sense held high from cycle 3 to 5.
   - act_a high cycles 1-4.
   - done=1 exactly once, about 2 cycles after sync latency; busy falls the same cycle.
   - act_b and act_chg stay 0.
2. A+change combination: cmd_1 and cmd_3 in the same cycle, with drop_sense then coin_sense each confirmed.
   - act_a 4-cycle pulse, then act_chg 4-cycle pulse; no overlap.
   - Single done after change is confirmed.
3. Timeout: cmd_2 with no drop_sense.
   - act_b high 4 cycles, then fault=1 after 8 WAIT cycles.
   - Actuators stay 0 and busy=1 until fault_clr.
   - One cycle after fault_clr, state is IDLE with fault=0 and busy=0.
4. Overrun/queue: cmd_2 at cycle 0, cmd_2 again at cycle 2, cmd_1 at cycle 3.
   - overrun=1 from cycle 3.
   - act_b runs first, then act_a.
   - Exactly two jobs serviced; a single done at the end.
5. Reset mid-pulse: assert reset during cycle 2 of act_a.
   - act_a drops asynchronously; all outputs are at reset values.
   - No job resumes after reset is released.
6. (VEND_COUNT_EN) Confirm 257 product dispenses -> vend_count=1. Confirmed change-only jobs leave it unchanged.
